// File: rtl/uart_core.sv
// uart_core: single-clock UART transceiver with runtime baud divisor, parity, 1/2 stop bits
// and a 16x-oversampled receiver with start-bit glitch rejection and error flags.
module uart_core #(
   parameter int DATA_BITS = 8,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W = 16
) (
   input  logic                 clkin,
   input  logic                 rst,
   input  logic [DIV_W-1:0]     baud_div,
   input  logic [1:0]           parity_mode,
   input  logic                 stop2,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_start,
   input  logic                 rx,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 rx_busy,
   output logic                 rx_done,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 baud_tick
);
   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_PAR = 3'd3;
   localparam logic [2:0] S_STOP = 3'd4;
   logic [DIV_W-1:0] probe_cnt;
   assign baud_tick = probe_cnt >= baud_div;
   always_ff @(posedge clkin)
      if (rst) probe_cnt <= '0;
      else probe_cnt <= baud_tick ? '0 : probe_cnt + 1'b1;
   logic [2:0] tx_state;
   logic [DIV_W-1:0] tx_div, tx_div_cnt;
   logic [OS_W-1:0] tx_os;
   logic [BW-1:0] tx_bit;
   logic [DATA_BITS-1:0] tx_sh;
   logic tx_par, tx_par_en, tx_stop2, tx_stop_cnt;
   logic tx_tick, tx_bit_end;
   assign tx_tick = tx_div_cnt >= tx_div;
   assign tx_bit_end = tx_tick && tx_os == OS_LAST;
   assign tx_busy = tx_state != S_IDLE;
   // tx is registered and already holds the level of the current bit; bit_end loads the next one
   always_ff @(posedge clkin)
      if (rst) begin
         tx_state <= S_IDLE;
         tx <= 1'b1;
         tx_done <= 1'b0;
         tx_div <= '0;
         tx_div_cnt <= '0;
         tx_os <= '0;
         tx_bit <= '0;
         tx_sh <= '0;
         tx_par <= 1'b0;
         tx_par_en <= 1'b0;
         tx_stop2 <= 1'b0;
         tx_stop_cnt <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         if (tx_state == S_IDLE) begin
            tx_div_cnt <= '0;
            tx_os <= '0;
            tx_bit <= '0;
            tx_stop_cnt <= 1'b0;
            if (tx_start) begin
               tx_state <= S_START;
               tx <= 1'b0;
               tx_sh <= tx_data;
               tx_div <= baud_div;
               tx_par <= ^tx_data ^ (parity_mode == 2'b10);
               tx_par_en <= ^parity_mode;
               tx_stop2 <= stop2;
            end
         end else begin
            tx_div_cnt <= tx_tick ? '0 : tx_div_cnt + 1'b1;
            if (tx_tick) tx_os <= tx_bit_end ? '0 : tx_os + 1'b1;
            if (tx_bit_end)
               case (tx_state)
                  S_START: begin
                     tx <= tx_sh[0];
                     tx_sh <= tx_sh >> 1;
                     tx_state <= S_DATA;
                  end
                  S_DATA:
                     if (tx_bit == BIT_LAST) begin
                        tx <= tx_par_en ? tx_par : 1'b1;
                        tx_state <= tx_par_en ? S_PAR : S_STOP;
                     end else begin
                        tx <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                        tx_bit <= tx_bit + 1'b1;
                     end
                  S_PAR: begin
                     tx <= 1'b1;
                     tx_state <= S_STOP;
                  end
                  default:
                     if (tx_stop_cnt == tx_stop2) begin
                        tx_state <= S_IDLE;
                        tx_done <= 1'b1;
                     end else tx_stop_cnt <= 1'b1;
               endcase
         end
      end
   logic rx_s1, rx_s2, rx_d;
   logic [2:0] rx_state;
   logic [DIV_W-1:0] rx_div, rx_div_cnt;
   logic [OS_W-1:0] rx_os;
   logic [BW-1:0] rx_bit;
   logic [DATA_BITS-1:0] rx_sh;
   logic rx_par_en, rx_odd, rx_acc, rx_perr;
   logic rx_tick, rx_samp;
   assign rx_tick = rx_div_cnt >= rx_div;
   assign rx_samp = rx_tick && rx_os == (rx_state == S_START ? OS_HALF : OS_LAST);
   assign rx_busy = rx_state != S_IDLE;
   // rx_acc folds the data bits so the parity check is a single XOR at the parity sample
   always_ff @(posedge clkin)
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_d <= 1'b1;
         rx_state <= S_IDLE;
         rx_div <= '0;
         rx_div_cnt <= '0;
         rx_os <= '0;
         rx_bit <= '0;
         rx_sh <= '0;
         rx_par_en <= 1'b0;
         rx_odd <= 1'b0;
         rx_acc <= 1'b0;
         rx_perr <= 1'b0;
         rx_done <= 1'b0;
         rx_data <= '0;
         parity_err <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_d <= rx_s2;
         rx_done <= 1'b0;
         if (rx_state == S_IDLE) begin
            rx_div_cnt <= '0;
            rx_os <= '0;
            rx_bit <= '0;
            rx_acc <= 1'b0;
            rx_perr <= 1'b0;
            if (rx_d && !rx_s2) begin
               rx_state <= S_START;
               rx_div <= baud_div;
               rx_par_en <= ^parity_mode;
               rx_odd <= parity_mode == 2'b10;
            end
         end else begin
            rx_div_cnt <= rx_tick ? '0 : rx_div_cnt + 1'b1;
            if (rx_tick) rx_os <= rx_samp ? '0 : rx_os + 1'b1;
            if (rx_samp)
               case (rx_state)
                  S_START: rx_state <= rx_s2 ? S_IDLE : S_DATA;
                  S_DATA: begin
                     rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
                     rx_acc <= rx_acc ^ rx_s2;
                     rx_bit <= rx_bit + 1'b1;
                     if (rx_bit == BIT_LAST) rx_state <= rx_par_en ? S_PAR : S_STOP;
                  end
                  S_PAR: begin
                     rx_perr <= rx_acc ^ rx_s2 ^ rx_odd;
                     rx_state <= S_STOP;
                  end
                  default: begin
                     rx_data <= rx_sh;
                     parity_err <= rx_perr;
                     frame_err <= ~rx_s2;
                     rx_done <= 1'b1;
                     rx_state <= S_IDLE;
                  end
               endcase
         end
      end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed stimulus with expected TX frames and RX results queued in scoreboards,
// checked by negedge monitors.
module tb_uart_core;
   typedef struct packed {
      logic [15:0] bits;
      int nbits;
      int per;
   } tx_exp_t;
   typedef struct packed {
      logic [7:0] data;
      logic perr;
      logic ferr;
   } rx_exp_t;
   logic clk = 1'b0;
   logic rst;
   logic [15:0] baud_div;
   logic [1:0] parity_mode;
   logic stop2;
   logic [7:0] tx_data0;
   logic tx_start0;
   logic [6:0] tx_data7;
   logic tx_start7;
   logic rx_drv, rx7, loopback, rx_line;
   logic tx0, tx_busy0, tx_done0, rx_busy0, rx_done0, parity_err0, frame_err0, baud_tick0;
   logic [7:0] rx_data0;
   logic tx7, tx_busy7, tx_done7, rx_busy7, rx_done7, parity_err7, frame_err7, baud_tick7;
   logic [6:0] rx_data7;
   int n_tests = 0;
   int n_fail = 0;
   tx_exp_t txq[2][$];
   rx_exp_t rxq[$];
   always #5 clk = ~clk;
   assign rx_line = loopback ? tx0 : rx_drv;
   uart_core dut (
      .clkin(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
      .tx_data(tx_data0), .tx_start(tx_start0), .rx(rx_line), .tx(tx0), .tx_busy(tx_busy0),
      .tx_done(tx_done0), .rx_busy(rx_busy0), .rx_done(rx_done0), .rx_data(rx_data0),
      .parity_err(parity_err0), .frame_err(frame_err0), .baud_tick(baud_tick0)
   );
   uart_core #(.DATA_BITS(7)) dut7 (
      .clkin(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode), .stop2(stop2),
      .tx_data(tx_data7), .tx_start(tx_start7), .rx(rx7), .tx(tx7), .tx_busy(tx_busy7),
      .tx_done(tx_done7), .rx_busy(rx_busy7), .rx_done(rx_done7), .rx_data(rx_data7),
      .parity_err(parity_err7), .frame_err(frame_err7), .baud_tick(baud_tick7)
   );
   logic tx_w[2], busy_w[2], done_w[2];
   assign tx_w[0] = tx0;
   assign tx_w[1] = tx7;
   assign busy_w[0] = tx_busy0;
   assign busy_w[1] = tx_busy7;
   assign done_w[0] = tx_done0;
   assign done_w[1] = tx_done7;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask
   function automatic tx_exp_t mk_tx(input logic [15:0] bits, input int nbits, input int per);
      mk_tx.bits = bits;
      mk_tx.nbits = nbits;
      mk_tx.per = per;
   endfunction
   function automatic rx_exp_t mk_rx(input logic [7:0] data, input logic perr, input logic ferr);
      mk_rx.data = data;
      mk_rx.perr = perr;
      mk_rx.ferr = ferr;
   endfunction
   tx_exp_t cur[2];
   int cnt[2];
   logic act[2], bq[2];
   always @(negedge clk)
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            act[k] = 1'b0;
            bq[k] = 1'b0;
         end else begin
            if (busy_w[k] && !bq[k]) begin
               check("tx_frame_expected", 32'(txq[k].size() != 0), 1);
               if (txq[k].size() != 0) begin
                  cur[k] = txq[k].pop_front();
                  act[k] = 1'b1;
                  cnt[k] = 0;
               end
            end else if (act[k]) cnt[k]++;
            if (act[k]) begin
               if (cnt[k] < cur[k].nbits * cur[k].per && cnt[k] % cur[k].per == cur[k].per / 2)
                  check($sformatf("tx%0d_bit%0d", k, cnt[k] / cur[k].per), 32'(tx_w[k]),
                        32'(cur[k].bits[cnt[k] / cur[k].per]));
               if (done_w[k]) begin
                  check("tx_done_time", cnt[k], cur[k].nbits * cur[k].per);
                  act[k] = 1'b0;
               end
            end else if (done_w[k]) check("tx_spurious_done", 32'(done_w[k]), 0);
            bq[k] = busy_w[k];
         end
      end
   always @(negedge clk)
      if (!rst && rx_done0) begin
         check("rx_frame_expected", 32'(rxq.size() != 0), 1);
         if (rxq.size() != 0) begin
            rx_exp_t e;
            e = rxq.pop_front();
            check("rx_data", 32'(rx_data0), 32'(e.data));
            check("rx_parity_err", 32'(parity_err0), 32'(e.perr));
            check("rx_frame_err", 32'(frame_err0), 32'(e.ferr));
         end
      end
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic wait_busy(input int k, input string name, input int budget);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (!busy_w[k] && n < budget);
      check(name, 32'(busy_w[k]), 1);
   endtask
   task automatic wait_done(input int k, input string name, input int budget, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!done_w[k] && n < budget);
      check(name, 32'(done_w[k]), 1);
   endtask
   task automatic send_rx(input logic [15:0] bits, input int nbits, input int per);
      for (int i = 0; i < nbits; i++) begin
         rx_drv = bits[i];
         tick(per);
      end
      rx_drv = 1'b1;
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      int n, tk0, tk7;
      logic saw;
      rst = 1'b1;
      baud_div = '0;
      parity_mode = 2'b00;
      stop2 = 1'b0;
      tx_data0 = '0;
      tx_start0 = 1'b0;
      tx_data7 = '0;
      tx_start7 = 1'b0;
      rx_drv = 1'b1;
      rx7 = 1'b1;
      loopback = 1'b0;
      tick(3);
      check("reset_tx", 32'(tx0), 1);
      check("reset_tx_busy", 32'(tx_busy0), 0);
      check("reset_tx_done", 32'(tx_done0), 0);
      check("reset_rx_busy", 32'(rx_busy0), 0);
      check("reset_rx_done", 32'(rx_done0), 0);
      check("reset_rx_data", 32'(rx_data0), 0);
      check("reset_parity_err", 32'(parity_err0), 0);
      check("reset_frame_err", 32'(frame_err0), 0);
      check("reset7_outputs", 32'({tx7, tx_busy7, tx_done7, rx_busy7, rx_done7, parity_err7, frame_err7}),
            32'(7'b1000000));
      check("reset7_rx_data", 32'(rx_data7), 0);
      rst = 1'b0;
      tick(2);
      // 8N1, baud_div 0, 0xA5
      txq[0].push_back(mk_tx({6'b0, 1'b1, 8'hA5, 1'b0}, 10, 16));
      tx_data0 = 8'hA5;
      tx_start0 = 1'b1;
      tick(1);
      tx_start0 = 1'b0;
      check("a5_tx_low_after_accept", 32'(tx0), 0);
      check("a5_busy_after_accept", 32'(tx_busy0), 1);
      wait_done(0, "a5_done_seen", 400, n);
      check("a5_done_latency", 1 + n, 161);
      check("a5_busy_clear_at_done", 32'(tx_busy0), 0);
      tick(5);
      // even parity loopback, baud_div 3, back-to-back
      baud_div = 16'd3;
      parity_mode = 2'b01;
      loopback = 1'b1;
      txq[0].push_back(mk_tx({5'b0, 1'b1, 1'b0, 8'h00, 1'b0}, 11, 64));
      txq[0].push_back(mk_tx({5'b0, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 64));
      txq[0].push_back(mk_tx({5'b0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 64));
      rxq.push_back(mk_rx(8'h00, 1'b0, 1'b0));
      rxq.push_back(mk_rx(8'hFF, 1'b0, 1'b0));
      rxq.push_back(mk_rx(8'h5A, 1'b0, 1'b0));
      tx_data0 = 8'h00;
      tx_start0 = 1'b1;
      wait_busy(0, "lb_accept0", 5);
      tx_data0 = 8'hFF;
      wait_done(0, "lb_done0", 2000, n);
      wait_busy(0, "lb_accept1", 5);
      tx_data0 = 8'h5A;
      wait_done(0, "lb_done1", 2000, n);
      wait_busy(0, "lb_accept2", 5);
      tx_start0 = 1'b0;
      wait_done(0, "lb_done2", 2000, n);
      tick(5);
      check("lb_rx_all_received", rxq.size(), 0);
      loopback = 1'b0;
      tick(10);
      // odd parity, wrong parity bit on 0x3C
      baud_div = 16'd1;
      parity_mode = 2'b10;
      rxq.push_back(mk_rx(8'h3C, 1'b1, 1'b0));
      send_rx({5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 32);
      tick(40);
      check("perr_rx_received", rxq.size(), 0);
      // stop bit forced low, 8N1
      baud_div = 16'd0;
      parity_mode = 2'b00;
      rxq.push_back(mk_rx(8'h96, 1'b0, 1'b1));
      send_rx({6'b0, 1'b0, 8'h96, 1'b0}, 10, 16);
      tick(48);
      check("ferr_rx_received", rxq.size(), 0);
      // 5-tick low glitch on idle line
      saw = 1'b0;
      for (int i = 0; i < 30; i++) begin
         rx_drv = i < 5 ? 1'b0 : 1'b1;
         tick(1);
         if (rx_busy0) saw = 1'b1;
      end
      check("glitch_rx_busy_pulsed", 32'(saw), 1);
      check("glitch_rx_busy_dropped", 32'(rx_busy0), 0);
      check("glitch_rx_data_held", 32'(rx_data0), 32'h96);
      check("glitch_parity_err_held", 32'(parity_err0), 0);
      check("glitch_frame_err_held", 32'(frame_err0), 1);
      // reset during TX bit 4
      txq[0].push_back(mk_tx({6'b0, 1'b1, 8'h3C, 1'b0}, 10, 16));
      tx_data0 = 8'h3C;
      tx_start0 = 1'b1;
      tick(1);
      tx_start0 = 1'b0;
      tick(70);
      check("pre_rst_busy", 32'(tx_busy0), 1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rst_mid_tx_line", 32'(tx0), 1);
      check("rst_mid_tx_busy", 32'(tx_busy0), 0);
      tick(20);
      tx_data0 = 8'h77;
      tx_start0 = 1'b1;
      rst = 1'b1;
      tick(1);
      tx_start0 = 1'b0;
      rst = 1'b0;
      tick(1);
      check("rst_beats_start_busy", 32'(tx_busy0), 0);
      check("rst_beats_start_line", 32'(tx0), 1);
      txq[0].push_back(mk_tx({6'b0, 1'b1, 8'hC3, 1'b0}, 10, 16));
      tx_data0 = 8'hC3;
      tx_start0 = 1'b1;
      tick(1);
      tx_start0 = 1'b0;
      wait_done(0, "fresh_done_seen", 400, n);
      check("fresh_done_latency", 1 + n, 161);
      tick(5);
      // DATA_BITS=7, two stop bits, re-pulse while busy, config changed mid-frame
      stop2 = 1'b1;
      txq[1].push_back(mk_tx({6'b0, 2'b11, 7'h55, 1'b0}, 10, 16));
      tx_data7 = 7'h55;
      tx_start7 = 1'b1;
      tick(1);
      tx_start7 = 1'b0;
      tick(40);
      tx_data7 = 7'h2A;
      tx_start7 = 1'b1;
      tick(2);
      tx_start7 = 1'b0;
      baud_div = 16'd5;
      stop2 = 1'b0;
      parity_mode = 2'b01;
      wait_done(1, "tx7_done_seen", 400, n);
      check("tx7_frame_length", 1 + 40 + 2 + n, 161);
      baud_div = 16'd0;
      parity_mode = 2'b00;
      tick(40);
      check("tx7_request_dropped", 32'(tx_busy7), 0);
      // free-running probe divider
      baud_div = 16'd2;
      tick(6);
      tk0 = 0;
      tk7 = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         tk0 += 32'(baud_tick0);
         tk7 += 32'(baud_tick7);
      end
      tick(1);
      check("baud_tick_rate", tk0, 10);
      check("baud_tick_rate7", tk7, 10);
      tick(5);
      check("tx_queue_drained", txq[0].size() + txq[1].size(), 0);
      check("rx_queue_drained", rxq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
